// File: rtl/wb_stage.sv
// Writeback stage: latches execute results, waits on data-memory responses for
// loads, formats load data and drives the register-file write port.
module wb_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [31:0]     ex_instruction,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [1:0]      ex_wb_sel,
  input  logic            ex_reg_wr,
  input  logic            flush,
  input  logic            dmem_rsp_valid,
  input  logic [31:0]     dmem_rdata,
  output logic [31:0]     instruction3,
  output logic [XLEN-1:0] wdata,
  output logic            reg_wr,
  output logic            stall,
  output logic            misaligned,
  output logic [63:0]     instret
);

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e          state_q, state_d;
  logic [31:0]     instruction3_q, instruction3_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            reg_wr_q, reg_wr_d;
  logic            misaligned_q, misaligned_d;
  logic [63:0]     instret_q, instret_d;
  logic [1:0]      off_q, off_d;
  logic            ld_reg_wr_q, ld_reg_wr_d;
  logic            retire;

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{off, 3'b000} +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    case (f3)
      3'd0:    fmt_load = XLEN'($signed(b));
      3'd4:    fmt_load = XLEN'(b);
      3'd1:    fmt_load = XLEN'($signed(h));
      3'd5:    fmt_load = XLEN'(h);
      3'd2:    fmt_load = XLEN'(raw);
      default: fmt_load = '0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0, 3'd4: is_misaligned = 1'b0;
      3'd1, 3'd5: is_misaligned = off[0];
      3'd2:       is_misaligned = (off != 2'd0);
      default:    is_misaligned = 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    instruction3_d = instruction3_q;
    wdata_d        = wdata_q;
    reg_wr_d       = 1'b0;
    misaligned_d   = 1'b0;
    off_d          = off_q;
    ld_reg_wr_d    = ld_reg_wr_q;
    retire         = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && !flush) begin
          instruction3_d = ex_instruction;
          off_d          = ex_alu_result[1:0];
          ld_reg_wr_d    = ex_reg_wr;
          if (ex_wb_sel == 2'b01) begin
            state_d = WAIT_LOAD;
          end else begin
            wdata_d  = (ex_wb_sel == 2'b10) ? ex_pc + XLEN'(4) : ex_alu_result;
            // rd==x0 suppresses the write but the instruction still retires
            reg_wr_d = ex_reg_wr && (ex_instruction[11:7] != 5'd0);
            retire   = 1'b1;
          end
        end else begin
          instruction3_d = NOP_INSN;
        end
      end
      WAIT_LOAD: begin
        if (flush) begin
          state_d        = IDLE;
          instruction3_d = NOP_INSN;
        end else if (dmem_rsp_valid) begin
          state_d = IDLE;
          if (is_misaligned(instruction3_q[14:12], off_q)) begin
            misaligned_d = 1'b1;
          end else begin
            wdata_d  = fmt_load(instruction3_q[14:12], off_q, dmem_rdata);
            reg_wr_d = ld_reg_wr_q && (instruction3_q[11:7] != 5'd0);
            retire   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    instret_d = instret_q + 64'(retire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      instruction3_q <= NOP_INSN;
      wdata_q        <= '0;
      reg_wr_q       <= 1'b0;
      misaligned_q   <= 1'b0;
      instret_q      <= '0;
      off_q          <= '0;
      ld_reg_wr_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      instruction3_q <= instruction3_d;
      wdata_q        <= wdata_d;
      reg_wr_q       <= reg_wr_d;
      misaligned_q   <= misaligned_d;
      instret_q      <= instret_d;
      off_q          <= off_d;
      ld_reg_wr_q    <= ld_reg_wr_d;
    end
  end

  assign instruction3 = instruction3_q;
  assign wdata        = wdata_q;
  assign reg_wr       = reg_wr_q;
  assign stall        = (state_q == WAIT_LOAD);
  assign misaligned   = misaligned_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected output snapshots are queued with each
// stimulus step and popped/compared just after the following clock edge.
module tb_wb_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADD5 = 32'h0020_82B3; // add x5,x1,x2
  localparam logic [31:0] JAL1 = 32'h0000_00EF; // jal x1,0
  localparam logic [31:0] ADDI0= 32'h0050_0013; // addi x0,x0,5
  localparam logic [31:0] LB7  = 32'h0000_8383; // lb x7,0(x1)
  localparam logic [31:0] LHU8 = 32'h0000_D403; // lhu x8,0(x1)
  localparam logic [31:0] LW9  = 32'h0000_A483; // lw x9,0(x1)

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_instruction, ex_alu_result, ex_pc;
  logic [1:0]  ex_wb_sel;
  logic        ex_reg_wr, flush, dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic [31:0] instruction3, wdata;
  logic        reg_wr, stall, misaligned;
  logic [63:0] instret;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] wdata;
    logic        reg_wr;
    logic        stall;
    logic        mis;
    logic [63:0] instret;
  } exp_t;

  exp_t sb[$];

  wb_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_instruction(ex_instruction),
    .ex_alu_result(ex_alu_result), .ex_pc(ex_pc), .ex_wb_sel(ex_wb_sel),
    .ex_reg_wr(ex_reg_wr), .flush(flush), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .instruction3(instruction3), .wdata(wdata),
    .reg_wr(reg_wr), .stall(stall), .misaligned(misaligned), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed time %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] insn, input logic [31:0] wd, input logic rw,
                      input logic st, input logic mis, input logic [63:0] ir);
    exp_t e;
    e.insn = insn; e.wdata = wd; e.reg_wr = rw; e.stall = st; e.mis = mis; e.instret = ir;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".instruction3"}, 64'(instruction3), 64'(e.insn));
      chk({tag, ".wdata"},        64'(wdata),        64'(e.wdata));
      chk({tag, ".reg_wr"},       64'(reg_wr),       64'(e.reg_wr));
      chk({tag, ".stall"},        64'(stall),        64'(e.stall));
      chk({tag, ".misaligned"},   64'(misaligned),   64'(e.mis));
      chk({tag, ".instret"},      instret,           e.instret);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [1:0] sel, input logic rw,
                       input logic fl, input logic rv, input logic [31:0] rd);
    ex_valid = v; ex_instruction = insn; ex_alu_result = alu; ex_pc = pc;
    ex_wb_sel = sel; ex_reg_wr = rw; flush = fl; dmem_rsp_valid = rv; dmem_rdata = rd;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 32'h0);
    #12;
    push(NOP, 32'h0, 0, 0, 0, 64'd0);
    check_now("reset");
    reset = 1'b1;

    drive(1, ADD5, 32'h1234, 32'h100, 2'b00, 1, 0, 0, 32'h0);
    push(ADD5, 32'h1234, 1, 0, 0, 64'd1);
    tick("alu_retire");
    drive(0, ADD5, 32'h1234, 32'h100, 2'b00, 1, 0, 0, 32'h0);
    push(NOP, 32'h1234, 0, 0, 0, 64'd1);
    tick("alu_idle");

    drive(1, JAL1, 32'hDEAD, 32'hFFFF_FFFC, 2'b10, 1, 0, 0, 32'h0);
    push(JAL1, 32'h0, 1, 0, 0, 64'd2);
    tick("jal_wrap");
    drive(1, ADDI0, 32'h55, 32'h200, 2'b00, 1, 0, 0, 32'h0);
    push(ADDI0, 32'h55, 0, 0, 0, 64'd3);
    tick("rd_x0");
    drive(1, ADD5, 32'h77, 32'h204, 2'b11, 1, 0, 1, 32'hFFFF_FFFF);
    push(ADD5, 32'h77, 1, 0, 0, 64'd4);
    tick("wbsel_11");

    // LB x7 at offset 3, response in third wait cycle
    drive(1, LB7, 32'h1003, 32'h300, 2'b01, 1, 0, 0, 32'h0);
    push(LB7, 32'h77, 0, 1, 0, 64'd4);
    tick("lb_capture");
    drive(1, ADD5, 32'h9999, 32'h304, 2'b00, 1, 0, 0, 32'hAAAA_AAAA);
    push(LB7, 32'h77, 0, 1, 0, 64'd4);
    tick("lb_wait2");
    push(LB7, 32'h77, 0, 1, 0, 64'd4);
    tick("lb_wait3");
    drive(1, ADD5, 32'h9999, 32'h304, 2'b00, 1, 0, 1, 32'h80FF_0000);
    push(LB7, 32'hFFFF_FF80, 1, 0, 0, 64'd5);
    tick("lb_data");
    drive(0, ADD5, 32'h0, 32'h0, 2'b00, 0, 0, 0, 32'h0);
    push(NOP, 32'hFFFF_FF80, 0, 0, 0, 64'd5);
    tick("lb_after");

    drive(1, LHU8, 32'h2002, 32'h400, 2'b01, 1, 0, 0, 32'h0);
    push(LHU8, 32'hFFFF_FF80, 0, 1, 0, 64'd5);
    tick("lhu_capture");
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 32'h0);
    push(LHU8, 32'hFFFF_FF80, 0, 1, 0, 64'd5);
    tick("lhu_wait");
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 1, 32'h80FF_0000);
    push(LHU8, 32'h0000_80FF, 1, 0, 0, 64'd6);
    tick("lhu_data");

    drive(1, LW9, 32'h3002, 32'h500, 2'b01, 1, 0, 0, 32'h0);
    push(LW9, 32'h0000_80FF, 0, 1, 0, 64'd6);
    tick("mis_capture");
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 1, 32'h1234_5678);
    push(LW9, 32'h0000_80FF, 0, 0, 1, 64'd6);
    tick("mis_pulse");
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 32'h0);
    push(NOP, 32'h0000_80FF, 0, 0, 0, 64'd6);
    tick("mis_drop");

    drive(1, LW9, 32'h4000, 32'h600, 2'b01, 1, 0, 0, 32'h0);
    push(LW9, 32'h0000_80FF, 0, 1, 0, 64'd6);
    tick("flush_capture");
    drive(1, ADD5, 32'h1111, 32'h604, 2'b00, 1, 1, 1, 32'hAABB_CCDD);
    push(NOP, 32'h0000_80FF, 0, 0, 0, 64'd6);
    tick("flush_wait");
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 1, 32'hAABB_CCDD);
    push(NOP, 32'h0000_80FF, 0, 0, 0, 64'd6);
    tick("stray_rsp");
    drive(1, ADD5, 32'h2222, 32'h700, 2'b00, 1, 1, 0, 32'h0);
    push(NOP, 32'h0000_80FF, 0, 0, 0, 64'd6);
    tick("flush_idle");

    drive(1, LW9, 32'h5000, 32'h800, 2'b01, 1, 0, 0, 32'h0);
    push(LW9, 32'h0000_80FF, 0, 1, 0, 64'd6);
    tick("lw_capture");
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 1, 32'h1234_5678);
    push(LW9, 32'h1234_5678, 1, 0, 0, 64'd7);
    tick("lw_data");

    // asynchronous reset between edges while a load is pending
    drive(1, LB7, 32'h6001, 32'h900, 2'b01, 1, 0, 0, 32'h0);
    push(LB7, 32'h1234_5678, 0, 1, 0, 64'd7);
    tick("rst_capture");
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    push(NOP, 32'h0, 0, 0, 0, 64'd0);
    check_now("async_reset");
    #1;
    reset = 1'b1;
    drive(0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 1, 32'hFFFF_FFFF);
    push(NOP, 32'h0, 0, 0, 0, 64'd0);
    tick("rsp_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 3-stage RV32I pipeline, sitting directly downstream of execute.
- Latches execute results and waits for the data-memory response on loads.
- Formats load data by funct3 and byte offset.
- Drives the register file write port (instruction3, wdata, reg_wr); the register file writes on the negedge inside the writeback cycle.
- Also provides a stall to upstream, a misalignment flag and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSN, 32'h0000_0013, instruction word held in instruction3 when the stage is empty (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_instruction  in  32  instruction word from execute.
- ex_alu_result  in  XLEN  ALU result or load effective address.
- ex_pc  in  XLEN  instruction PC.
- ex_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- ex_reg_wr  in  1  instruction writes rd.
- flush  in  1  kill the instruction being captured or waited on.
- dmem_rsp_valid  in  1  load data valid this cycle.
- dmem_rdata  in  32  raw aligned word from data memory.
- instruction3  out  32  instruction in writeback; to the register file write address.
- wdata  out  XLEN  register file write data.
- reg_wr  out  1  register file write enable.
- stall  out  1  upstream must hold its outputs.
- misaligned  out  1  one-cycle pulse on a misaligned load.
- instret  out  64  retired-instruction count.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, instruction3=NOP_INSN, wdata=0, reg_wr=0, misaligned=0, instret=0.
  - Internal captured fields are cleared.
  - stall=0 because state is IDLE.
- States:
  - IDLE: accepting.
  - WAIT_LOAD: a load is captured and its response is pending.
- stall = (state==WAIT_LOAD). It is combinational from the state flop only.
- IDLE, posedge with ex_valid=1 and flush=0:
  - Capture instruction, alu_result, pc, wb_sel and reg_wr.
  - wb_sel=01: go to WAIT_LOAD. instruction3 updates, reg_wr=0.
  - Otherwise: wdata = alu_result (00/11) or pc+4 (10), mod 2^XLEN; reg_wr = ex_reg_wr; instruction3 = ex_instruction. These are valid for exactly one cycle (latency 1).
- IDLE, posedge with ex_valid=0 or flush=1: reg_wr=0, instruction3=NOP_INSN, wdata holds.
- WAIT_LOAD, posedge with dmem_rsp_valid=1 and flush=0:
  - Format dmem_rdata using captured funct3 (instruction[14:12]) and offset o = alu_result[1:0].
  - LB and LBU: byte at bits [8o+7:8o]; LB sign-extends, LBU zero-extends.
  - LH and LHU: halfword at o[1]; LH sign-extends, LHU zero-extends.
  - LW: full word.
  - Misaligned when LH/LHU has o[0]=1, LW has o≠0, or funct3 is 3, 6 or 7. On misalignment: reg_wr=0, misaligned=1 for one cycle, no retire.
  - Otherwise: wdata = formatted value, reg_wr = captured reg_wr.
  - Return to IDLE in both cases.
  - No capture on this edge, because stall was high.
- WAIT_LOAD, posedge with flush=1: return to IDLE, reg_wr=0, instruction3=NOP_INSN, no retire. flush has priority over dmem_rsp_valid.
- dmem_rsp_valid in IDLE is ignored.
- reg_wr is forced to 0 when instruction3[11:7]==0. This is redundant with the register file, but keeps instret semantics independent of rd.
- instret increments by 1 on each edge that produces a completed non-flushed, non-misaligned instruction, whether or not it writes rd. It wraps at 2^64.
- Reset asserted mid-WAIT_LOAD aborts the load; a response arriving after reset is ignored.
- No combinational path from dmem_rsp_valid or ex_* to any output.

Test Plan:
- ALU retire: reset, then ex_valid=1 with add x5, alu_result=32'h1234, wb_sel=00, reg_wr=1 -> next cycle reg_wr=1, wdata=32'h1234, instruction3[11:7]=5, instret=1; the cycle after, reg_wr=0.
- JAL link: pc=32'hFFFF_FFFC, wb_sel=10 -> wdata=32'h0000_0000 (wrap), reg_wr=1.
- Load with 3-cycle latency: LB x7, offset 3, response in the 3rd wait cycle with dmem_rdata=32'h80FF_0000 -> stall high for 3 cycles, then wdata=32'hFFFF_FF80, reg_wr=1, stall=0.
  - Repeat with LHU, offset 2 -> wdata=32'h0000_80FF.
- Misaligned load: LW with offset 2, response arrives -> misaligned pulses 1 cycle, reg_wr=0, instret unchanged, state IDLE.
- Flush during wait: LW pending, flush=1 together with dmem_rsp_valid=1 -> no write, instruction3=NOP_INSN, stall drops next cycle. A stray response later in IDLE is ignored.
- Async reset mid-load: drive reset=0 between clock edges while in WAIT_LOAD -> stall, reg_wr and instret drop to 0 immediately. After release, a response produces no write.
